// File: rtl/fp8_stream_accumulator.sv
// Streaming FP8 E4M3 reducer: folds accepted beats into a running sum that is
// rounded at every step, and emits the result on the beat marked last.

module fp8_e4m3_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum
);
  // Magnitude as an exact integer in units of 2^-9, the subnormal LSB.
  function automatic logic [19:0] mag(input logic [7:0] x);
    logic [19:0] sig;
    sig = {16'd0, (x[6:3] != 4'd0), x[2:0]};
    if (x[6:3] == 4'd0) mag = sig;
    else                mag = sig << (x[6:3] - 4'd1);
  endfunction

  logic [19:0] ma, mb, rmag, rem, half;
  logic [3:0]  kept;
  logic [4:0]  lead, shift, ex, mant;
  logic        rsign, rup, nan;

  always_comb begin
    nan = (a[6:0] == 7'h7F) || (b[6:0] == 7'h7F);
    ma  = mag(a);
    mb  = mag(b);
    rsign = a[7];
    if (a[7] == b[7])  rmag = ma + mb;
    else if (ma >= mb) rmag = ma - mb;
    else begin
      rmag  = mb - ma;
      rsign = b[7];
    end
    lead = '0;
    for (int i = 0; i < 20; i++)
      if (rmag[i]) lead = 5'(i);
    // Keep the hidden bit plus 3 mantissa bits; round the rest to nearest-even.
    shift = (lead > 5'd3) ? lead - 5'd3 : 5'd0;
    kept  = 4'(rmag >> shift);
    rem   = rmag & ((20'd1 << shift) - 20'd1);
    half  = (shift == 5'd0) ? 20'd0 : (20'd1 << (shift - 5'd1));
    rup   = (shift != 5'd0) && ((rem > half) || ((rem == half) && kept[0]));
    mant  = {1'b0, kept} + {4'd0, rup};
    ex    = lead - 5'd2;
    if (mant[4]) begin
      ex   = ex + 5'd1;
      mant = 5'd8;
    end
    if (rmag < 20'd8)
      sum = (rmag == 20'd0) ? 8'h00 : {rsign, 4'd0, rmag[2:0]};
    else if ((ex > 5'd15) || ((ex == 5'd15) && (mant[2:0] == 3'd7)))
      sum = {rsign, 7'h7E};
    else
      sum = {rsign, ex[3:0], mant[2:0]};
    if (nan) sum = 8'h7F;
  end
endmodule

module fp8_stream_accumulator #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_data,
  output logic               out_nan,
  output logic [COUNT_W-1:0] out_count
);
  typedef enum logic {ACC, DONE} state_t;

  state_t             state, state_nxt;
  logic [7:0]         acc, acc_sum;
  logic               nan_flag, nan_nxt, fire, out_fire;
  logic [COUNT_W-1:0] count, count_inc;

  fp8_e4m3_adder u_add (.a(acc), .b(in_data), .sum(acc_sum));

  assign in_ready  = (state == ACC);
  assign fire      = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign nan_nxt   = nan_flag || (in_data[6:0] == 7'h7F);
  assign count_inc = (&count) ? count : count + COUNT_W'(1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (fire && in_last) state_nxt = DONE;
      DONE: if (out_fire)        state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= 8'h00;
      nan_flag  <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_nan   <= 1'b0;
      out_count <= '0;
    end else begin
      if (fire) begin
        if (in_last) begin
          // Final beat lands straight in the output registers; accumulator restarts.
          acc       <= 8'h00;
          nan_flag  <= 1'b0;
          count     <= '0;
          out_data  <= acc_sum;
          out_nan   <= nan_nxt;
          out_count <= count_inc;
          out_valid <= 1'b1;
        end else begin
          acc      <= acc_sum;
          nan_flag <= nan_nxt;
          count    <= count_inc;
        end
      end
      if (out_fire) begin
        out_valid <= 1'b0;
        out_data  <= 8'h00;
        out_nan   <= 1'b0;
        out_count <= '0;
      end
    end
  end
endmodule
